prm_edge_chk_sched: RTL and testbench
=====================================

# prm_edge_chk_sched

Scan scheduler for the PRM edge-validity checker bank. It accepts a stream of 15-bit obstacle occupancy words and drives each word onto the shared input bus of the combinational `prm_oblgc_chk*` array, one word per cycle. It ORs the returned per-edge masks into a blocked-edge accumulator. At end of scan it publishes the free-edge bitmap to the roadmap planner.

## Interface
Parameters:
- `NUM_EDGE`, 64: number of checker instances, which is also the edge bitmap width.
- `OCC_W`, 15: occupancy word width, matching checker inputs A..O with A as the LSB.
- `CNT_W`, 16: width of the word counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begins a scan. Honoured only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when `edge_free` is updated.
- `obs_valid` in 1: occupancy word valid.
- `obs_ready` out 1: high only in SCAN.
- `obs_data` in OCC_W: occupancy word.
- `obs_last` in 1: marks the final word of the scan.
- `chk_in` out OCC_W: registered bus to the checker array.
- `chk_mask` in NUM_EDGE: combinational `edge_mask` outputs of the array for the current `chk_in`.
- `edge_free` out NUM_EDGE: result bitmap, 1 = edge collision-free.
- `obs_cnt` out CNT_W: number of words checked in the last scan.

## Operation
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - `obs_ready`=0.
  - On `start`: clear `blocked`, the stage-valid flag `sv` and the counter, then go to SCAN.
- SCAN:
  - `obs_ready`=1.
  - On each handshake (`obs_valid`&`obs_ready`):
    - `chk_in` <= `obs_data`.
    - `sv` <= 1.
    - counter += 1, saturating at all-ones.
  - With no handshake, `sv` <= 0 and `chk_in` holds its value.
  - A handshake with `obs_last`=1 moves the FSM to DRAIN.
- Accumulate: in every cycle with `sv`=1, `blocked` <= `blocked` | `chk_mask`.
- DRAIN: one cycle in which the final word's mask is accumulated. `sv` <= 0. Go to DONE.
- DONE:
  - `edge_free` <= ~`blocked`.
  - `obs_cnt` <= counter.
  - `done`=1.
  - Go to IDLE.
- `start` outside IDLE is ignored; in particular, `start` during DONE does not restart the scan.
- A scan always contains at least one word; a scan ends only on a word with `obs_last`=1.
- `edge_free` and `obs_cnt` hold their values between scans.

## Timing
- Reset values:
  - FSM = IDLE.
  - `busy`=0, `done`=0, `obs_ready`=0, `sv`=0.
  - `chk_in`=0.
  - `blocked`=0.
  - `edge_free`=0, so every edge reads as blocked until the first scan completes.
  - `obs_cnt`=0.
- `start` sampled at cycle t gives `busy`=1 and `obs_ready`=1 at t+1.
- A word accepted at cycle t appears on `chk_in` at t+1. Its mask is folded into `blocked` at the end of t+1.
- Last word accepted at cycle t:
  - DRAIN at t+1.
  - DONE with `done`=1 at t+2.
  - The new `edge_free` is visible at t+3.
  - IDLE at t+3.
- Sustained throughput: one word per cycle. Back-to-back scans need at least 3 idle cycles between them (DRAIN, DONE, IDLE).
- `rst` asserted mid-scan returns every register to its reset value on the next edge. A partial scan result is never published.
- Counter saturation: words beyond 2^CNT_W−1 are still checked; `obs_cnt` reads all-ones.

## Configuration
- `PRM_SCHED_EARLY_EN` defined:
  - Once `blocked` is all-ones during SCAN, handshakes still complete until `obs_last`, because the stream must drain.
  - In that condition `chk_in` holds, `sv` stays 0 and the counter stops, which saves checker toggling.
  - `obs_cnt` then reports only the words actually checked.
- `PRM_SCHED_EARLY_EN` undefined: every accepted word is checked and counted.

## Structure
- Shared package `prm_sched_pkg`:
  - FSM state enum `prm_sched_state_t`.
  - `PRM_OCC_W`=15.
  - Default `PRM_NUM_EDGE`.
- One natural sub-module, `prm_edge_acc`:
  - Holds the `blocked` register, the OR-accumulate, the all-ones detect and the clear.
  - Instantiated once.
- The checker array sits outside this block; the two connect only through `chk_in` and `chk_mask`.

## Test plan
- Reset mid-scan:
  - Stimulus: accept 3 words, then assert `rst`.
  - Required: all outputs return to their reset values; `edge_free`=0; no `done` pulse; a following scan behaves normally.
- Single-word scan:
  - Stimulus: `obs_data`=15'h0000 with `obs_last`, bench model returns a mask of 0.
  - Required: `done` exactly 2 cycles after acceptance; `edge_free`=all-ones; `obs_cnt`=1.
- Three-word scan:
  - Stimulus: masks 64'h1, 64'h100, 64'h1 delivered back-to-back.
  - Required: `edge_free`=~64'h101; `obs_cnt`=3; `chk_in` trails each handshake by one cycle.
- Backpressure and bubbles:
  - Stimulus: `obs_valid` toggles 1,0,0,1(last).
  - Required: only 2 words are accumulated; `obs_cnt`=2; a bubble re-folds no stale mask.
- `start` during a busy state:
  - Stimulus: pulse `start` during SCAN and again during DONE.
  - Required: both are ignored; exactly one `done` pulse.
- With `PRM_SCHED_EARLY_EN` defined:
  - Stimulus: the first word's mask is all-ones, followed by 4 more words, the last of which carries `obs_last`.
  - Required: `chk_in` frozen after the first word; `obs_cnt`=1; `edge_free`=0.

Source files
------------

// File: rtl/prm_sched_pkg.sv
// Shared types and defaults for the PRM edge-checker scan scheduler.
package prm_sched_pkg;

  localparam int unsigned PRM_OCC_W    = 15;
  localparam int unsigned PRM_NUM_EDGE = 64;
  localparam int unsigned PRM_CNT_W    = 16;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDrain,
    StDone
  } prm_sched_state_t;

endpackage

// File: rtl/prm_edge_acc.sv
// Blocked-edge accumulator: ORs per-edge checker masks into a sticky register.
module prm_edge_acc #(
  parameter int unsigned NumEdge = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               sv_i,
  input  logic [NumEdge-1:0] mask_i,
  output logic [NumEdge-1:0] blocked_o,
  output logic               full_o
);

  logic [NumEdge-1:0] blocked_q;
  logic [NumEdge-1:0] blocked_nxt;

  assign blocked_nxt = blocked_q | (sv_i ? mask_i : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      blocked_q <= '0;
    end else if (clr_i) begin
      blocked_q <= '0;
    end else if (sv_i) begin
      blocked_q <= blocked_nxt;
    end
  end

  assign blocked_o = blocked_q;
  // Looks ahead through the mask in flight so the very next word can already be skipped.
  assign full_o    = &blocked_nxt;

endmodule

// File: rtl/prm_edge_chk_sched.sv
// Scan scheduler feeding occupancy words to the PRM edge-checker array.
// Optional build macro PRM_SCHED_EARLY_EN: stop checking once every edge is blocked.
module prm_edge_chk_sched
  import prm_sched_pkg::*;
#(
  parameter int unsigned NUM_EDGE = PRM_NUM_EDGE,
  parameter int unsigned OCC_W    = PRM_OCC_W,
  parameter int unsigned CNT_W    = PRM_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  input  logic                obs_valid,
  output logic                obs_ready,
  input  logic [OCC_W-1:0]    obs_data,
  input  logic                obs_last,
  output logic [OCC_W-1:0]    chk_in,
  input  logic [NUM_EDGE-1:0] chk_mask,
  output logic [NUM_EDGE-1:0] edge_free,
  output logic [CNT_W-1:0]    obs_cnt
);

`ifdef PRM_SCHED_EARLY_EN
  localparam bit EarlyEn = 1'b1;
`else
  localparam bit EarlyEn = 1'b0;
`endif

  prm_sched_state_t    state_q;
  logic                busy_q;
  logic                done_q;
  logic                obs_ready_q;
  logic                sv_q;
  logic [OCC_W-1:0]    chk_in_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [NUM_EDGE-1:0] edge_free_q;
  logic [CNT_W-1:0]    obs_cnt_q;

  logic                hs;
  logic                hs_chk;
  logic                acc_clr;
  logic                acc_full;
  logic [NUM_EDGE-1:0] blocked;

  assign hs      = obs_valid & obs_ready_q;
  // A word accepted while everything is already blocked is drained but not checked.
  assign hs_chk  = hs & ~(EarlyEn & acc_full);
  assign acc_clr = (state_q == StIdle) & start;

  prm_edge_acc #(
    .NumEdge (NUM_EDGE)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (acc_clr),
    .sv_i      (sv_q),
    .mask_i    (chk_mask),
    .blocked_o (blocked),
    .full_o    (acc_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      obs_ready_q <= 1'b0;
      sv_q        <= 1'b0;
      chk_in_q    <= '0;
      cnt_q       <= '0;
      edge_free_q <= '0;
      obs_cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StScan;
            busy_q      <= 1'b1;
            obs_ready_q <= 1'b1;
            sv_q        <= 1'b0;
            cnt_q       <= '0;
          end
        end
        StScan: begin
          if (hs_chk) begin
            chk_in_q <= obs_data;
            sv_q     <= 1'b1;
            if (cnt_q != '1) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            sv_q <= 1'b0;
          end
          if (hs && obs_last) begin
            state_q     <= StDrain;
            obs_ready_q <= 1'b0;
          end
        end
        StDrain: begin
          sv_q    <= 1'b0;
          state_q <= StDone;
          done_q  <= 1'b1;
        end
        StDone: begin
          edge_free_q <= ~blocked;
          obs_cnt_q   <= cnt_q;
          state_q     <= StIdle;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign obs_ready = obs_ready_q;
  assign chk_in    = chk_in_q;
  assign edge_free = edge_free_q;
  assign obs_cnt   = obs_cnt_q;

endmodule

// File: tb/tb_prm_edge_chk_sched.sv
// Directed self-checking bench for prm_edge_chk_sched with a table-driven checker model.
module tb_prm_edge_chk_sched;

  localparam int unsigned NE = 64;
  localparam int unsigned OW = 15;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          obs_valid;
  logic          obs_ready;
  logic [OW-1:0] obs_data;
  logic          obs_last;
  logic [OW-1:0] chk_in;
  logic [NE-1:0] chk_mask;
  logic [NE-1:0] edge_free;
  logic [CW-1:0] obs_cnt;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  // Stand-in for the combinational checker array.
  function automatic logic [NE-1:0] mask_of(input logic [OW-1:0] w);
    case (w)
      15'h0001: mask_of = 64'h1;
      15'h0002: mask_of = 64'h100;
      15'h0003: mask_of = '1;
      15'h0004: mask_of = 64'h10;
      default:  mask_of = '0;
    endcase
  endfunction

  assign chk_mask = mask_of(chk_in);

  prm_edge_chk_sched dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .obs_valid (obs_valid),
    .obs_ready (obs_ready),
    .obs_data  (obs_data),
    .obs_last  (obs_last),
    .chk_in    (chk_in),
    .chk_mask  (chk_mask),
    .edge_free (edge_free),
    .obs_cnt   (obs_cnt)
  );

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [NE-1:0] got, input logic [NE-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", {63'd0, busy}, 64'd1);
    check("start_ready", {63'd0, obs_ready}, 64'd1);
  endtask

  // Presents one word for one cycle; returns at the negedge after acceptance.
  task automatic push(input logic [OW-1:0] d, input logic last);
    obs_valid = 1'b1;
    obs_data  = d;
    obs_last  = last;
    @(negedge clk);
    obs_valid = 1'b0;
    obs_last  = 1'b0;
  endtask

  task automatic bubble();
    @(negedge clk);
  endtask

  // Called in the cycle after the last word was accepted.
  task automatic finish_scan(input string tag, input logic [NE-1:0] exp_free,
                             input logic [CW-1:0] exp_cnt);
    int d0;
    d0 = done_cnt;
    check({tag, "_done_early"}, {63'd0, done}, 64'd0);
    @(negedge clk);
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    @(negedge clk);
    check({tag, "_done_fall"}, {63'd0, done}, 64'd0);
    check({tag, "_free"}, edge_free, exp_free);
    check({tag, "_cnt"}, {48'd0, obs_cnt}, {48'd0, exp_cnt});
    check({tag, "_idle"}, {63'd0, busy}, 64'd0);
    check({tag, "_npulse"}, 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    int d0;
    rst       = 1'b1;
    start     = 1'b0;
    obs_valid = 1'b0;
    obs_data  = '0;
    obs_last  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_ready", {63'd0, obs_ready}, 64'd0);
    check("rst_chk_in", {49'd0, chk_in}, 64'd0);
    check("rst_free", edge_free, 64'd0);
    check("rst_cnt", {48'd0, obs_cnt}, 64'd0);

    // Reset in the middle of a scan.
    d0 = done_cnt;
    do_start();
    push(15'h0001, 1'b0);
    push(15'h0002, 1'b0);
    push(15'h0004, 1'b0);
    check("mid_chk_in", {49'd0, chk_in}, 64'h4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_busy", {63'd0, busy}, 64'd0);
    check("mid_ready", {63'd0, obs_ready}, 64'd0);
    check("mid_chk_in0", {49'd0, chk_in}, 64'd0);
    check("mid_free", edge_free, 64'd0);
    check("mid_cnt", {48'd0, obs_cnt}, 64'd0);
    repeat (3) @(negedge clk);
    check("mid_nodone", 64'(done_cnt - d0), 64'd0);
    check("mid_free_hold", edge_free, 64'd0);

    // Single-word scan.
    do_start();
    push(15'h0000, 1'b1);
    check("one_chk_in", {49'd0, chk_in}, 64'd0);
    finish_scan("one", '1, 16'd1);

    // Three back-to-back words.
    do_start();
    push(15'h0001, 1'b0);
    check("three_chk_in0", {49'd0, chk_in}, 64'h1);
    push(15'h0002, 1'b0);
    check("three_chk_in1", {49'd0, chk_in}, 64'h2);
    push(15'h0001, 1'b1);
    check("three_chk_in2", {49'd0, chk_in}, 64'h1);
    finish_scan("three", ~64'h101, 16'd3);
    check("three_free_hold", edge_free, ~64'h101);

    // Valid pattern 1,0,0,1(last).
    do_start();
    push(15'h0001, 1'b0);
    bubble();
    bubble();
    check("bub_chk_hold", {49'd0, chk_in}, 64'h1);
    push(15'h0004, 1'b1);
    finish_scan("bub", ~64'h11, 16'd2);

    // Start pulses during SCAN and DONE are ignored.
    d0 = done_cnt;
    do_start();
    push(15'h0002, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_scan_ready", {63'd0, obs_ready}, 64'd1);
    push(15'h0001, 1'b1);
    @(negedge clk);
    check("busy_done", {63'd0, done}, 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_idle", {63'd0, busy}, 64'd0);
    check("busy_free", edge_free, ~64'h101);
    check("busy_cnt", {48'd0, obs_cnt}, 64'd2);
    repeat (3) @(negedge clk);
    check("busy_norestart", {63'd0, busy}, 64'd0);
    check("busy_npulse", 64'(done_cnt - d0), 64'd1);

    // First word blocks every edge.
    do_start();
    push(15'h0003, 1'b0);
    push(15'h0001, 1'b0);
    push(15'h0002, 1'b0);
    push(15'h0004, 1'b0);
    push(15'h0004, 1'b1);
`ifdef PRM_SCHED_EARLY_EN
    check("full_chk_in", {49'd0, chk_in}, 64'h3);
    finish_scan("full", 64'd0, 16'd1);
`else
    check("full_chk_in", {49'd0, chk_in}, 64'h4);
    finish_scan("full", 64'd0, 16'd5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
